// File: rtl/norm_seq.sv
// Multi-cycle normalizer: binary search (WIDTH/2 .. 1) for the left shift that
// normalizes a word, one stage per clock, with a start/busy/done handshake.
module norm_seq #(
    parameter int WIDTH = 32,
    parameter int SAW   = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [SAW-1:0]   sa,
    output logic             zero
);

    // state | meaning
    // IDLE  | waiting for start; q/sa/zero hold the last result
    // RUN   | one search stage per edge, step size 2^r_k, r_k counts down to 0
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SAW-1:0] SA_ONE = {{(SAW-1){1'b0}}, 1'b1};
    localparam logic [SAW-1:0] K_LAST = SAW'(SAW - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SAW-1:0]   r_k;
    logic [SAW-1:0]   w_k_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [SAW-1:0]   r_sa;
    logic [SAW-1:0]   w_sa_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic             r_arith;
    logic             w_arith_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic [SAW-1:0]   w_n;
    logic [SAW-1:0]   w_n1;
    logic [WIDTH-1:0] w_mask_n;
    logic [WIDTH-1:0] w_mask_s;
    logic [WIDTH-1:0] w_top_n;
    logic [WIDTH-1:0] w_top_s;
    logic             w_hit;
    logic [WIDTH-1:0] w_q_shift;
    logic [SAW-1:0]   w_sa_add;

    // Step size n = 2^k never exceeds WIDTH/2, and n+1 never exceeds WIDTH-1,
    // so both fit in SAW bits for any legal WIDTH.
    assign w_n  = SA_ONE << r_k;
    assign w_n1 = w_n + SA_ONE;

    // Masks select the top n (logical) or top n+1 (signed) bits of q.
    assign w_mask_n = ~({WIDTH{1'b1}} >> w_n);
    assign w_mask_s = ~({WIDTH{1'b1}} >> w_n1);
    assign w_top_n  = r_q & w_mask_n;
    assign w_top_s  = r_q & w_mask_s;

    assign w_hit = r_arith ? ((w_top_s == '0) || (w_top_s == w_mask_s))
                           : (w_top_n == '0);

    assign w_q_shift = r_q << w_n;
    assign w_sa_add  = r_sa + w_n;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_q_nxt     = r_q;
        w_sa_nxt    = r_sa;
        w_zero_nxt  = r_zero;
        w_arith_nxt = r_arith;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_q_nxt     = d;
                    w_sa_nxt    = '0;
                    w_zero_nxt  = (d == '0);
                    w_arith_nxt = arith;
                    w_k_nxt     = K_LAST;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_hit) begin
                    w_q_nxt  = w_q_shift;
                    w_sa_nxt = w_sa_add;
                end
                if (r_k == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_k_nxt = r_k - SA_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_q     <= '0;
            r_sa    <= '0;
            r_zero  <= 1'b0;
            r_arith <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_q     <= w_q_nxt;
            r_sa    <= w_sa_nxt;
            r_zero  <= w_zero_nxt;
            r_arith <= w_arith_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign q    = r_q;
    assign sa   = r_sa;
    assign zero = r_zero;

endmodule

// File: tb/tb_norm_seq.sv
// Directed + randomized bench for norm_seq; expected results are queued at
// start and compared when done pulses.
module tb_norm_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [4:0]  sa;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        clrn;
    logic        start;
    logic [31:0] d;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [4:0]  sa;
    logic        zero;

    exp_t sb[$];
    exp_t last;
    int   n_tests = 0;
    int   n_fail  = 0;

    norm_seq #(.WIDTH(32), .SAW(5)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .d     (d),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .sa    (sa),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Linear reference: shift one bit at a time, capped at 31.
    function automatic exp_t model(input logic [31:0] dv, input logic av);
        exp_t e;
        e.q    = dv;
        e.sa   = 5'd0;
        e.zero = (dv == 32'd0);
        for (int i = 0; i < 31; i++) begin
            if (av ? (e.q[31] == e.q[30]) : !e.q[31]) begin
                e.q  = e.q << 1;
                e.sa = e.sa + 5'd1;
            end else begin
                break;
            end
        end
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_q"},    q,         32'd0);
        check({tag, "_sa"},   32'(sa),   32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd0);
    endtask

    task automatic start_op(input logic [31:0] dv, input logic av,
                            input logic [31:0] eq, input logic [4:0] esa, input logic ez);
        exp_t e;
        e.q = eq; e.sa = esa; e.zero = ez;
        start = 1'b1;
        d     = dv;
        arith = av;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int   cnt   = 0;
        int   guard = 0;
        exp_t e;
        while (done !== 1'b1 && guard < 30) begin
            if (busy === 1'b1) cnt++;
            guard++;
            @(negedge clk);
        end
        check({tag, "_done_seen"},  32'(done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_q"},    q,         e.q);
            check({tag, "_sa"},   32'(sa),   32'(e.sa));
            check({tag, "_zero"}, 32'(zero), 32'(e.zero));
            last = e;
        end
    endtask

    task automatic done_clears(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] dv;
        logic        av;

        clrn  = 1'b0;
        start = 1'b0;
        d     = 32'd0;
        arith = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        clrn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all_zero("idle");
        end

        start_op(32'h0000_1234, 1'b0, 32'h91A0_0000, 5'd19, 1'b0);
        wait_done("log_1234", 5);
        done_clears("log_1234");
        start_op(32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0, 1'b0);
        wait_done("log_norm", 5);
        done_clears("log_norm");

        start_op(32'hFFFF_F000, 1'b1, 32'h8000_0000, 5'd19, 1'b0);
        wait_done("sgn_fffff000", 5);
        done_clears("sgn_fffff000");
        start_op(32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0);
        wait_done("sgn_one", 5);
        done_clears("sgn_one");
        start_op(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b0);
        wait_done("sgn_ones", 5);
        done_clears("sgn_ones");

        start_op(32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1);
        wait_done("zero_log", 5);
        done_clears("zero_log");
        start_op(32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1);
        wait_done("zero_sgn", 5);
        done_clears("zero_sgn");
        start_op(32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
        wait_done("after_zero", 5);
        done_clears("after_zero");

        // Second start two cycles into a run must be ignored.
        start_op(32'h0000_0F00, 1'b0, 32'hF000_0000, 5'd20, 1'b0);
        @(negedge clk);
        start = 1'b1;
        d     = 32'hFFFF_FFFF;
        arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start", 3);

        // Back-to-back start in the done cycle.
        start_op(32'h0000_0400, 1'b0, 32'h8000_0000, 5'd21, 1'b0);
        check("b2b_busy_rise", 32'(busy), 32'd1);
        check("b2b_done_low",  32'(done), 32'd0);
        wait_done("b2b", 5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_q",    q,         last.q);
            check("hold_sa",   32'(sa),   32'(last.sa));
            check("hold_zero", 32'(zero), 32'(last.zero));
            check("hold_done", 32'(done), 32'd0);
        end

        // Reset at step 2 aborts the run without a done pulse.
        start_op(32'h1234_5678, 1'b0, 32'h91A2_B3C0, 5'd3, 1'b0);
        repeat (2) @(negedge clk);
        clrn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("held_reset");
        end
        clrn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_done", 32'(done), 32'd0);
        end
        start_op(32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8, 1'b0);
        wait_done("post_reset_run", 5);
        done_clears("post_reset_run");

        for (int i = 0; i < 16; i++) begin
            dv = $urandom >> $urandom_range(0, 31);
            if (i % 4 == 1) dv = ~dv;
            av = 1'(i % 2);
            e  = model(dv, av);
            start_op(dv, av, e.q, e.sa, e.zero);
            wait_done("rand", 5);
            done_clears("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/norm_seq.md
Name: norm_seq

Overview:
Multi-cycle normalizer for the ALU/FPU datapath. It is the inverse of the shift-amount-driven barrel shifter. Given a 32-bit word, it finds the left-shift amount that normalizes the word and returns both the shifted word and that amount. The search is binary (16, 8, 4, 2, 1), one stage per clock, under a start/busy/done handshake. Typical uses are the FP add/sub normalization path and CLZ/CLS-style instructions.

Parameters:
WIDTH, 32, data width; must be a power of two, at least 4.
SAW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
clk  input  1  clock; all state updates on the rising edge
clrn  input  1  asynchronous active-low reset (clear)
start  input  1  request; accepted only on an edge where busy=0
d  input  WIDTH  operand; sampled on the accepting edge only
arith  input  1  1: signed normalize (stop when q[31]!=q[30]); 0: logical (stop when q[31]=1); sampled with d
busy  output  1  high while a normalization is in progress
done  output  1  one-cycle pulse when q/sa/zero become valid
q  output  WIDTH  normalized word
sa  output  SAW  left-shift amount applied to d
zero  output  1  operand was all zeros

Behaviour:
- Reset (clrn=0, asynchronous): busy=0, done=0, q=0, sa=0, zero=0, state=IDLE. Reset during a run aborts the run with no done pulse.
- States: IDLE, RUN. The step counter k runs SAW-1 down to 0.
- IDLE, start=1 edge (E0):
  - load q<=d, sa<=0, zero<=(d==0), latch arith, k<=SAW-1, busy<=1, done<=0.
  - go to RUN.
- RUN, each edge at step k (n=2^k):
  - Logical: if q[WIDTH-1 -: n] is all 0, then q<=q<<n and sa<=sa+n.
  - Signed: if q[WIDTH-1 -: n+1] is all equal, then q<=q<<n (zero fill) and sa<=sa+n.
  - Otherwise q and sa are unchanged.
  - If k=0: busy<=0, done<=1, go to IDLE. Else k<=k-1.
- Latency: E0 plus SAW step edges (E1..E5). busy is high for 5 cycles. done is high in the cycle after E5. Throughput is one result per 6 cycles; back-to-back start on the cycle done is high is accepted.
- done is high exactly one cycle. It clears on the next edge regardless of start.
- q, sa and zero hold their values after done until the next accepted start. They are not valid while busy=1.
- start while busy=1 is ignored; d and arith changes during RUN have no effect.
- sa is the sum of the applied step sizes and never exceeds WIDTH-1, so no overflow is possible.
- Boundary cases:
  - d=0 (either mode): q=0, sa=31, zero=1.
  - d=0xFFFFFFFF with arith=1: q=0x80000000, sa=31, zero=0.
  - Already normalized operand: sa=0, q=d, still takes the full 5 steps.

Test Plan:
- Reset then idle: hold clrn=0, then release with start=0 for 10 cycles -> busy=0, done=0, q=0, sa=0, zero=0 throughout.
- Logical: start with d=0x00001234, arith=0 -> busy for 5 cycles, done pulse on the 6th cycle, q=0x91A00000, sa=19, zero=0. Then d=0x80000000 -> q=0x80000000, sa=0.
- Signed: start with d=0xFFFFF000, arith=1 -> q=0x80000000, sa=19. Then d=0x00000001, arith=1 -> q=0x40000000, sa=30. Then d=0xFFFFFFFF -> q=0x80000000, sa=31.
- Zero operand: start with d=0, arith=0 -> q=0, sa=31, zero=1. Then a following start with d=1 clears zero to 0 and gives q=0x80000000, sa=31.
- Handshake: pulse start again 2 cycles into a run with a different d -> ignored, and the result matches the first d. Start asserted in the done cycle -> a new run begins and busy rises on the next cycle. Results hold for 20 idle cycles after done.
- Reset mid-operation: drop clrn at step 2 -> all outputs 0 immediately, with no done pulse. After release, a fresh start with d=0x00F00000, arith=0 -> q=0xF0000000, sa=8.
